// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module  : mem_stage_pkg
// Brief   : Shared FSM encoding, WB control bit indices and width defaults
//           for the memory-access stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;

  localparam int REGWRITE = 3;
  localparam int MEMTOREG = 2;
  localparam int PCTOREG  = 1;
  localparam int HALT     = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/memwb_reg.sv
// ============================================================================
// Module  : memwb_reg
// Brief   : MEM/WB pipeline register with bubble insertion and load-data hold.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memwb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              mem_en,
  input  logic [3:0]        ctrl_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] reg_data_in,
  input  logic [REG_W-1:0]  dst_in,
  output logic [3:0]        ctrl,
  output logic [DATA_W-1:0] alu,
  output logic [DATA_W-1:0] mem,
  output logic [DATA_W-1:0] reg_data,
  output logic [REG_W-1:0]  dst
);

  // A bubble only clears control; the data fields keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      alu      <= '0;
      mem      <= '0;
      reg_data <= '0;
      dst      <= '0;
    end else if (bubble) begin
      ctrl     <= '0;
    end else begin
      ctrl     <= ctrl_in;
      alu      <= alu_in;
      reg_data <= reg_data_in;
      dst      <= dst_in;
      if (mem_en) begin
        mem <= mem_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module  : mem_stage
// Brief   : Pipeline memory stage: variable-latency handshake, MEM-to-MEM
//           store-data forwarding, stall generation and MEM/WB register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_write,
  input  logic              ex_mem_read,
  input  logic [3:0]        ex_wb,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_reg_data,
  input  logic [DATA_W-1:0] ex_rt,
  input  logic [REG_W-1:0]  ex_dst,
  input  logic [REG_W-1:0]  ex_src2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [3:0]        wb_ctrl,
  output logic [DATA_W-1:0] wb_alu,
  output logic [DATA_W-1:0] wb_mem,
  output logic [DATA_W-1:0] wb_reg_data,
  output logic [REG_W-1:0]  wb_dst
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] wdata_hold, wdata_hold_nxt;
  logic              access;
  logic              fwd;
  logic [DATA_W-1:0] fwd_data;

  assign access   = ex_mem_read | ex_mem_write;
  assign fwd      = ex_mem_write & wb_ctrl[REGWRITE] & wb_ctrl[MEMTOREG]
                  & (wb_dst == ex_src2) & (wb_dst != '0);
  assign fwd_data = fwd ? wb_mem : ex_rt;
  assign stall    = access & ~mem_ack;
  assign mem_addr = ex_alu;
  assign mem_we   = ex_mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wdata_hold <= '0;
    end else begin
      state      <= state_nxt;
      wdata_hold <= wdata_hold_nxt;
    end
  end

  // The stall bubble wipes the forwarding source, so capture store data
  // on entry to WAIT and replay it for the rest of the access.
  always_comb begin
    state_nxt      = state;
    wdata_hold_nxt = wdata_hold;
    mem_req        = 1'b0;
    mem_wdata      = fwd_data;
    case (state)
      IDLE: begin
        mem_req = access;
        if (access && !mem_ack) begin
          state_nxt      = WAIT;
          wdata_hold_nxt = fwd_data;
        end
      end
      WAIT: begin
        mem_req   = 1'b1;
        mem_wdata = wdata_hold;
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  memwb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_memwb_reg (
    .clk         (clk),
    .rst         (rst),
    .bubble      (stall),
    .mem_en      (access & mem_ack),
    .ctrl_in     (ex_wb),
    .alu_in      (ex_alu),
    .mem_in      (mem_rdata),
    .reg_data_in (ex_reg_data),
    .dst_in      (ex_dst),
    .ctrl        (wb_ctrl),
    .alu         (wb_alu),
    .mem         (wb_mem),
    .reg_data    (wb_reg_data),
    .dst         (wb_dst)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module  : tb_mem_stage
// Brief   : Directed self-checking bench for mem_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_write, ex_mem_read;
  logic [3:0]  ex_wb;
  logic [15:0] ex_alu, ex_reg_data, ex_rt;
  logic [3:0]  ex_dst, ex_src2;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [3:0]  wb_ctrl;
  logic [15:0] wb_alu, wb_mem, wb_reg_data;
  logic [3:0]  wb_dst;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_write (ex_mem_write),
    .ex_mem_read  (ex_mem_read),
    .ex_wb        (ex_wb),
    .ex_alu       (ex_alu),
    .ex_reg_data  (ex_reg_data),
    .ex_rt        (ex_rt),
    .ex_dst       (ex_dst),
    .ex_src2      (ex_src2),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .stall        (stall),
    .wb_ctrl      (wb_ctrl),
    .wb_alu       (wb_alu),
    .wb_mem       (wb_mem),
    .wb_reg_data  (wb_reg_data),
    .wb_dst       (wb_dst)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ex_mem_write = 1'b0; ex_mem_read = 1'b0; ex_wb = 4'h0;
    ex_alu = 16'h0; ex_reg_data = 16'h0; ex_rt = 16'h0; ex_dst = 4'h0;
    ex_src2 = 4'h0; mem_rdata = 16'h0; mem_ack = 1'b0;
    step(); step();
    check("rst_wb_ctrl", wb_ctrl, 4'h0);
    check("rst_wb_alu", wb_alu, 16'h0);
    check("rst_wb_mem", wb_mem, 16'h0);
    check("rst_wb_reg_data", wb_reg_data, 16'h0);
    check("rst_wb_dst", wb_dst, 4'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // Zero-wait load
    ex_mem_read = 1'b1; ex_alu = 16'h0040; ex_wb = 4'b1100; ex_dst = 4'd3;
    ex_reg_data = 16'h0022; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    check("zw_stall", stall, 1'b0);
    check("zw_req", mem_req, 1'b1);
    check("zw_we", mem_we, 1'b0);
    check("zw_addr", mem_addr, 16'h0040);
    step();
    check("zw_wb_mem", wb_mem, 16'hBEEF);
    check("zw_wb_ctrl", wb_ctrl, 4'b1100);
    check("zw_wb_dst", wb_dst, 4'd3);
    check("zw_wb_alu", wb_alu, 16'h0040);
    check("zw_wb_reg_data", wb_reg_data, 16'h0022);

    // 3-cycle store, no forwarding (src2 differs from wb_dst)
    ex_mem_read = 1'b0; ex_mem_write = 1'b1; ex_alu = 16'h0100; ex_rt = 16'h1234;
    ex_src2 = 4'd7; ex_wb = 4'b1000; ex_dst = 4'd9; mem_ack = 1'b0; mem_rdata = 16'h5555;
    #1;
    check("st_c1_req", mem_req, 1'b1);
    check("st_c1_we", mem_we, 1'b1);
    check("st_c1_wdata", mem_wdata, 16'h1234);
    check("st_c1_addr", mem_addr, 16'h0100);
    check("st_c1_stall", stall, 1'b1);
    step();
    check("st_e1_wb_ctrl", wb_ctrl, 4'h0);
    check("st_e1_wb_alu_hold", wb_alu, 16'h0040);
    check("st_c2_req", mem_req, 1'b1);
    check("st_c2_wdata", mem_wdata, 16'h1234);
    check("st_c2_stall", stall, 1'b1);
    step();
    check("st_e2_wb_ctrl", wb_ctrl, 4'h0);
    mem_ack = 1'b1;
    #1;
    check("st_c3_req", mem_req, 1'b1);
    check("st_c3_we", mem_we, 1'b1);
    check("st_c3_wdata", mem_wdata, 16'h1234);
    check("st_c3_stall", stall, 1'b0);
    step();
    check("st_done_wb_ctrl", wb_ctrl, 4'b1000);
    check("st_done_wb_dst", wb_dst, 4'd9);
    check("st_done_wb_alu", wb_alu, 16'h0100);
    check("st_done_wb_mem", wb_mem, 16'h5555);

    // Prime MEM/WB with a load of r5 = 0xA5A5
    ex_mem_write = 1'b0; ex_mem_read = 1'b1; ex_wb = 4'b1100; ex_dst = 4'd5;
    ex_alu = 16'h0050; mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    step();
    check("pre_fwd_wb_mem", wb_mem, 16'hA5A5);

    // MEM-to-MEM forwarding across a wait
    ex_mem_read = 1'b0; ex_mem_write = 1'b1; ex_src2 = 4'd5; ex_rt = 16'h0000;
    ex_alu = 16'h0200; ex_wb = 4'b0000; ex_dst = 4'd0; mem_ack = 1'b0; mem_rdata = 16'h0F0F;
    #1;
    check("fwd_c1_wdata", mem_wdata, 16'hA5A5);
    check("fwd_c1_stall", stall, 1'b1);
    step();
    check("fwd_e1_wb_ctrl", wb_ctrl, 4'h0);
    mem_ack = 1'b1;
    #1;
    check("fwd_c2_req", mem_req, 1'b1);
    check("fwd_c2_wdata", mem_wdata, 16'hA5A5);
    check("fwd_c2_stall", stall, 1'b0);
    step();
    check("fwd_done_wb_mem", wb_mem, 16'h0F0F);

    // Forwarding suppressed when the matching destination is r0
    ex_mem_write = 1'b0; ex_mem_read = 1'b1; ex_wb = 4'b1100; ex_dst = 4'd0;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    step();
    ex_mem_read = 1'b0; ex_mem_write = 1'b1; ex_src2 = 4'd0; ex_rt = 16'h4321;
    ex_wb = 4'b0000; mem_ack = 1'b0;
    #1;
    check("nofwd_c1_wdata", mem_wdata, 16'h4321);
    step();
    check("nofwd_c2_wdata", mem_wdata, 16'h4321);
    mem_ack = 1'b1;
    step();

    // Reset during the second wait cycle of a load
    ex_mem_write = 1'b0; ex_mem_read = 1'b1; ex_alu = 16'h0300; ex_wb = 4'b1100;
    ex_dst = 4'd6; ex_reg_data = 16'h0032; mem_ack = 1'b0;
    #1;
    check("rw_c1_stall", stall, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rw_wb_ctrl", wb_ctrl, 4'h0);
    check("rw_wb_alu", wb_alu, 16'h0);
    check("rw_wb_mem", wb_mem, 16'h0);
    check("rw_wb_reg_data", wb_reg_data, 16'h0);
    check("rw_wb_dst", wb_dst, 4'h0);
    check("rw_req_fresh", mem_req, 1'b1);
    check("rw_stall", stall, 1'b1);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    step();
    check("rw_done_wb_mem", wb_mem, 16'h1111);
    check("rw_done_wb_ctrl", wb_ctrl, 4'b1100);
    check("rw_done_wb_dst", wb_dst, 4'd6);

    // Stray ack with no access; non-memory pass-through
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_wb = 4'b1000; ex_alu = 16'h0007;
    ex_dst = 4'd2; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    check("stray_req", mem_req, 1'b0);
    check("stray_stall", stall, 1'b0);
    step();
    check("stray_wb_alu", wb_alu, 16'h0007);
    check("stray_wb_ctrl", wb_ctrl, 4'b1000);
    check("stray_wb_mem", wb_mem, 16'h1111);
    mem_ack = 1'b0;
    #1;
    check("idle_req", mem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
